// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM.
// Owns the PC, the instruction register and the retired-instruction counter.
module core_sequencer #(
  parameter int unsigned      PC_W     = 8,
  parameter logic [PC_W-1:0]  PC_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            step,
  output logic            imem_req,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] pc_addr,
  output logic [31:0]     ir,
  output logic [4:0]      rg_rd_addr1,
  output logic [4:0]      rg_rd_addr2,
  output logic [4:0]      rg_wrt_dest,
  output logic            rg_wrt_en,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_target,
  output logic            dmem_req,
  input  logic            dmem_ready,
  output logic            halted,
  output logic            illegal,
  output logic [2:0]      state,
  output logic [31:0]     instret
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMemory    = 3'd4,
    StWriteback = 3'd5,
    StHalt      = 3'd6
  } state_e;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [31:0]     instret_q, instret_d;
  logic            illegal_q, illegal_d;
  logic            taken_q, taken_d;
  logic [PC_W-1:0] target_q, target_d;

  logic [6:0] opcode;
  logic       writes_rd;
  logic       no_rd;
  logic       is_mem;

  assign opcode = ir_q[6:0];

  always_comb begin
    writes_rd = 1'b0;
    no_rd     = 1'b0;
    unique case (opcode)
      OpReg, OpImm, OpLoad, OpLui, OpAuipc, OpJal, OpJalr: writes_rd = 1'b1;
      OpStore, OpBranch:                                   no_rd     = 1'b1;
      default: ;
    endcase
  end

  assign is_mem = (opcode == OpLoad) || (opcode == OpStore);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    illegal_d = illegal_q;
    taken_d   = taken_q;
    target_d  = target_q;
    unique case (state_q)
      StIdle: begin
        if (run || step) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (opcode == OpSystem) begin
          illegal_d = 1'b0;
          state_d   = StHalt;
        end else if (!writes_rd && !no_rd) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        taken_d  = pc_load;
        target_d = pc_target;
        state_d  = is_mem ? StMemory : StWriteback;
      end
      StMemory: begin
        if (dmem_ready) state_d = StWriteback;
      end
      StWriteback: begin
        // Targets are forced word-aligned; sequential PC wraps naturally.
        pc_d      = taken_q ? {target_q[PC_W-1:2], 2'b00} : pc_q + PC_W'(4);
        instret_d = instret_q + 32'd1;
        state_d   = run ? StFetch : StIdle;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      taken_q   <= 1'b0;
      target_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
    end
  end

  // Strobes decode straight from the state register so reset drops them at once.
  assign imem_req    = (state_q == StFetch);
  assign dmem_req    = (state_q == StMemory);
  assign rg_wrt_en   = (state_q == StWriteback) && writes_rd && (ir_q[11:7] != 5'd0);
  assign halted      = (state_q == StHalt);
  assign illegal     = illegal_q;
  assign state       = state_q;
  assign pc_addr     = pc_q;
  assign ir          = ir_q;
  assign instret     = instret_q;
  assign rg_rd_addr1 = ir_q[19:15];
  assign rg_rd_addr2 = ir_q[24:20];
  assign rg_wrt_dest = ir_q[11:7];

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer: one task per scenario,
// expected values hand-derived from the instruction encodings used.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        step;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [7:0]  pc_addr;
  logic [31:0] ir;
  logic [4:0]  rg_rd_addr1;
  logic [4:0]  rg_rd_addr2;
  logic [4:0]  rg_wrt_dest;
  logic        rg_wrt_en;
  logic        pc_load;
  logic [7:0]  pc_target;
  logic        dmem_req;
  logic        dmem_ready;
  logic        halted;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] instret;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] InsAddi   = 32'h0050_0093;
  localparam logic [31:0] InsLoad   = 32'h0000_A103;
  localparam logic [31:0] InsStore  = 32'h0020_A023;
  localparam logic [31:0] InsBranch = 32'h0000_0063;
  localparam logic [31:0] InsBad    = 32'hFFFF_FFFF;
  localparam logic [31:0] InsEcall  = 32'h0000_0073;

  core_sequencer #(
    .PC_W     (8),
    .PC_RESET (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .step        (step),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .pc_addr     (pc_addr),
    .ir          (ir),
    .rg_rd_addr1 (rg_rd_addr1),
    .rg_rd_addr2 (rg_rd_addr2),
    .rg_wrt_dest (rg_wrt_dest),
    .rg_wrt_en   (rg_wrt_en),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .halted      (halted),
    .illegal     (illegal),
    .state       (state),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    run = 1'b0; step = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    pc_load = 1'b0; pc_target = '0; dmem_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    total++; if (pc_addr !== 8'h00) begin bad++; $display("FAIL rst_pc got=%h exp=00", pc_addr); end
    total++; if (ir !== 32'h0) begin bad++; $display("FAIL rst_ir got=%h exp=0", ir); end
    total++; if (instret !== 32'd0) begin bad++; $display("FAIL rst_instret got=%0d exp=0", instret); end
    total++; if ({imem_req, dmem_req, rg_wrt_en, halted, illegal} !== 5'b0) begin
      bad++; $display("FAIL rst_strobes got=%b exp=00000", {imem_req, dmem_req, rg_wrt_en, halted, illegal});
    end
  endtask

  task automatic test_addi();
    run = 1'b1; imem_rdata = InsAddi; imem_ready = 1'b1;
    tick();
    total++; if (state !== 3'd1 || imem_req !== 1'b1) begin
      bad++; $display("FAIL addi_fetch got=%0d/%b exp=1/1", state, imem_req);
    end
    tick();
    imem_ready = 1'b0;
    total++; if (state !== 3'd2 || ir !== InsAddi) begin
      bad++; $display("FAIL addi_decode got=%0d/%h exp=2/%h", state, ir, InsAddi);
    end
    total++; if ({rg_rd_addr1, rg_rd_addr2, rg_wrt_dest} !== {5'd0, 5'd5, 5'd1}) begin
      bad++; $display("FAIL addi_fields got=%0d/%0d/%0d exp=0/5/1", rg_rd_addr1, rg_rd_addr2, rg_wrt_dest);
    end
    tick();
    total++; if (state !== 3'd3 || rg_wrt_en !== 1'b0) begin
      bad++; $display("FAIL addi_exec got=%0d/%b exp=3/0", state, rg_wrt_en);
    end
    tick();
    total++; if (state !== 3'd5 || rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'd1 || pc_addr !== 8'h00) begin
      bad++; $display("FAIL addi_wb got=%0d/%b/%0d/%h exp=5/1/1/00", state, rg_wrt_en, rg_wrt_dest, pc_addr);
    end
    tick();
    total++; if (state !== 3'd1 || pc_addr !== 8'h04 || instret !== 32'd1) begin
      bad++; $display("FAIL addi_retire got=%0d/%h/%0d exp=1/04/1", state, pc_addr, instret);
    end
  endtask

  task automatic test_fetch_wait();
    int req_cycles = 0;
    imem_rdata = InsLoad;
    for (int i = 0; i < 4; i++) begin
      if (imem_req === 1'b1) req_cycles++;
      total++; if (state !== 3'd1 || pc_addr !== 8'h04 || ir !== InsAddi) begin
        bad++; $display("FAIL fwait_hold[%0d] got=%0d/%h/%h exp=1/04/%h", i, state, pc_addr, ir, InsAddi);
      end
      if (i == 3) imem_ready = 1'b1;
      tick();
    end
    imem_ready = 1'b0;
    total++; if (req_cycles != 4) begin bad++; $display("FAIL fwait_req got=%0d exp=4", req_cycles); end
    total++; if (state !== 3'd2 || ir !== InsLoad) begin
      bad++; $display("FAIL fwait_ir got=%0d/%h exp=2/%h", state, ir, InsLoad);
    end
  endtask

  task automatic test_load_store();
    int mem_cycles = 0;
    total++; if (rg_wrt_dest !== 5'd2 || rg_rd_addr1 !== 5'd1) begin
      bad++; $display("FAIL ld_fields got=%0d/%0d exp=2/1", rg_wrt_dest, rg_rd_addr1);
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      if (state === 3'd4 && dmem_req === 1'b1) mem_cycles++;
      if (i == 2) dmem_ready = 1'b1;
      tick();
    end
    dmem_ready = 1'b0;
    total++; if (mem_cycles != 3) begin bad++; $display("FAIL ld_mem_len got=%0d exp=3", mem_cycles); end
    total++; if (state !== 3'd5 || rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'd2 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL ld_wb got=%0d/%b/%0d/%b exp=5/1/2/0", state, rg_wrt_en, rg_wrt_dest, dmem_req);
    end
    imem_rdata = InsStore; imem_ready = 1'b1;
    tick();
    total++; if (pc_addr !== 8'h08 || instret !== 32'd2) begin
      bad++; $display("FAIL ld_retire got=%h/%0d exp=08/2", pc_addr, instret);
    end
    tick();
    imem_ready = 1'b0;
    tick();
    tick();
    total++; if (state !== 3'd4 || dmem_req !== 1'b1) begin
      bad++; $display("FAIL st_mem got=%0d/%b exp=4/1", state, dmem_req);
    end
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    total++; if (state !== 3'd5 || rg_wrt_en !== 1'b0) begin
      bad++; $display("FAIL st_wb got=%0d/%b exp=5/0", state, rg_wrt_en);
    end
  endtask

  task automatic test_branch();
    imem_rdata = InsBranch; imem_ready = 1'b1;
    tick();
    total++; if (pc_addr !== 8'h0C || instret !== 32'd3) begin
      bad++; $display("FAIL st_retire got=%h/%0d exp=0C/3", pc_addr, instret);
    end
    tick();
    imem_ready = 1'b0;
    tick();
    pc_load = 1'b1; pc_target = 8'h1E;
    tick();
    pc_load = 1'b0; pc_target = 8'h00; run = 1'b0;
    total++; if (state !== 3'd5 || rg_wrt_en !== 1'b0) begin
      bad++; $display("FAIL br_wb got=%0d/%b exp=5/0", state, rg_wrt_en);
    end
    tick();
    total++; if (state !== 3'd0 || pc_addr !== 8'h1C || instret !== 32'd4) begin
      bad++; $display("FAIL br_target got=%0d/%h/%0d exp=0/1C/4", state, pc_addr, instret);
    end
  endtask

  task automatic test_step();
    step = 1'b1; imem_rdata = InsBranch; imem_ready = 1'b1;
    tick();
    step = 1'b0;
    total++; if (state !== 3'd1) begin bad++; $display("FAIL step_start got=%0d exp=1", state); end
    tick();
    imem_ready = 1'b0; step = 1'b1;
    tick();
    step = 1'b0; pc_load = 1'b1; pc_target = 8'hFF;
    tick();
    pc_load = 1'b0; pc_target = 8'h00;
    tick();
    total++; if (state !== 3'd0 || pc_addr !== 8'hFC || instret !== 32'd5) begin
      bad++; $display("FAIL step_done got=%0d/%h/%0d exp=0/FC/5", state, pc_addr, instret);
    end
    tick();
    tick();
    total++; if (state !== 3'd0 || instret !== 32'd5 || imem_req !== 1'b0) begin
      bad++; $display("FAIL step_idle got=%0d/%0d/%b exp=0/5/0", state, instret, imem_req);
    end
  endtask

  task automatic test_wrap();
    step = 1'b1; imem_rdata = InsAddi; imem_ready = 1'b1;
    tick();
    step = 1'b0;
    tick();
    imem_ready = 1'b0;
    tick();
    tick();
    total++; if (state !== 3'd5 || rg_wrt_en !== 1'b1) begin
      bad++; $display("FAIL wrap_wb got=%0d/%b exp=5/1", state, rg_wrt_en);
    end
    tick();
    total++; if (state !== 3'd0 || pc_addr !== 8'h00 || instret !== 32'd6) begin
      bad++; $display("FAIL wrap_pc got=%0d/%h/%0d exp=0/00/6", state, pc_addr, instret);
    end
  endtask

  task automatic test_illegal();
    step = 1'b1; imem_rdata = InsBad; imem_ready = 1'b1;
    tick();
    step = 1'b0;
    tick();
    imem_ready = 1'b0;
    tick();
    total++; if (state !== 3'd6 || halted !== 1'b1 || illegal !== 1'b1) begin
      bad++; $display("FAIL ill_halt got=%0d/%b/%b exp=6/1/1", state, halted, illegal);
    end
    run = 1'b1;
    tick();
    tick();
    total++; if (state !== 3'd6 || pc_addr !== 8'h00 || instret !== 32'd6 || imem_req !== 1'b0) begin
      bad++; $display("FAIL ill_stuck got=%0d/%h/%0d/%b exp=6/00/6/0", state, pc_addr, instret, imem_req);
    end
  endtask

  task automatic test_ecall();
    apply_reset();
    run = 1'b1; imem_rdata = InsEcall; imem_ready = 1'b1;
    tick();
    tick();
    imem_ready = 1'b0;
    tick();
    total++; if (state !== 3'd6 || halted !== 1'b1 || illegal !== 1'b0 || instret !== 32'd0) begin
      bad++; $display("FAIL ecall_halt got=%0d/%b/%b/%0d exp=6/1/0/0", state, halted, illegal, instret);
    end
  endtask

  task automatic test_reset_fetch();
    apply_reset();
    run = 1'b1; imem_rdata = InsAddi; imem_ready = 1'b1;
    tick();
    tick();
    imem_ready = 1'b0;
    tick();
    tick();
    tick();
    total++; if (state !== 3'd1 || imem_req !== 1'b1 || pc_addr !== 8'h04) begin
      bad++; $display("FAIL rf_pre got=%0d/%b/%h exp=1/1/04", state, imem_req, pc_addr);
    end
    #2 reset = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0 || state !== 3'd0 || pc_addr !== 8'h00 || instret !== 32'd0) begin
      bad++; $display("FAIL rf_async got=%b/%0d/%h/%0d exp=0/0/00/0", imem_req, state, pc_addr, instret);
    end
    run = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rf_idle got=%0d exp=0", state); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_fetch_wait();
    test_load_store();
    test_branch();
    test_step();
    test_wrap();
    test_illegal();
    test_ecall();
    test_reset_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
